uart_port_ex: RTL and testbench
===============================

UART_PORT_EX -- requirements
Module: uart_port_ex

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter DEFAULT_BAUDRATE, default 9_600, used when div_x16 < 2.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of div_x16.
REQ-004 SHALL have parameters TX_FIFO_DEPTH, default 16, and RX_FIFO_DEPTH, default 64, both powers of two and at least 2.
REQ-005 SHALL use one clock and a synchronous active-high reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- uart_rx  in  1  asynchronous serial input, idle high.
- uart_tx  out  1  serial output, idle high.
- en  in  1  baud tick enable.
- div_x16  in  DIV_WIDTH  clocks per x16 tick; values 0 and 1 select the default divider.
- data_bits  in  2  data length code; 0..3 select 5..8 data bits.
- parity_mode  in  2  parity: 00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  1 = two stop bits.
- tx_valid / tx_ready / tx_data[7:0]  in/out/in  TX stream into the TX FIFO.
- rx_valid / rx_ready / rx_data[7:0]  out/in/out  RX stream from the RX FIFO head.
- rx_parity_err, rx_frame_err  out  1  flags for the head entry, valid with rx_valid.
- rx_overrun  out  1  sticky flag: a received byte was dropped.
- overrun_clr  in  1  pulse that clears rx_overrun.
- tx_busy, rx_busy  out  1  engine not idle.
- tx_level, rx_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-006 Baud generator SHALL pulse the x16 tick for one clk every DIV clocks while en=1; DIV = div_x16, or CLK_HZ/(16*DEFAULT_BAUDRATE) when div_x16 < 2; the counter SHALL hold at 0 while en=0.
REQ-007 tx_ready SHALL equal !TX FIFO full; a push occurs on tx_valid&&tx_ready; a push while full SHALL be impossible.
REQ-008 TX engine states SHALL be IDLE, START, DATA, PARITY, STOP; each bit lasts exactly 16 x16 ticks.
REQ-009 In IDLE with TX FIFO non-empty, the engine SHALL pop the FIFO and latch data_bits/parity_mode/stop2; uart_tx SHALL go low on the next clk edge.
REQ-010 Data SHALL be sent LSB first, with only the low N bits sent; PARITY SHALL be skipped when parity is none; the parity bit SHALL be XOR(data) for even and its inverse for odd; STOP SHALL last 16 ticks, or 32 ticks when stop2 is set.
REQ-011 Back-to-back frames SHALL have no idle gap when the FIFO is non-empty at STOP end.
REQ-012 uart_rx SHALL pass through a 2-flop synchroniser.
REQ-013 RX start detect SHALL be a high-to-low transition in IDLE; the line is sampled at tick 8, and the engine returns to IDLE if it is high (glitch); later bits are sampled at 16-tick intervals after that point.
REQ-014 RX SHALL latch configuration at start detect, assemble N bits zero-extended to 8, check parity, and check one stop bit only (the second stop bit is not checked); frame_err = sampled stop==0; parity_err = parity mismatch (0 when parity is none).
REQ-015 At the stop sample, {frame_err, parity_err, data} SHALL be written to the RX FIFO if it is not full; otherwise the byte is dropped and rx_overrun is set.
REQ-016 RX SHALL return to IDLE after the stop sample, even on frame error, and re-arm only after the line is seen high.
REQ-017 The RX FIFO SHALL be show-ahead: rx_valid = !empty, and rx_data/flags reflect the head combinationally; a pop occurs on rx_valid&&rx_ready.
REQ-018 A simultaneous push and pop on either FIFO SHALL leave the level unchanged; when full, a simultaneous RX push and pop SHALL be accepted (no overrun).
REQ-019 rx_overrun SHALL clear on overrun_clr; if a set and a clear occur in the same cycle, set wins.
REQ-020 Pointers SHALL wrap modulo DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-021 On rst, on a clk edge, all state SHALL clear: uart_tx=1; tx_ready=1; rx_valid=0; rx_data=0; flags=0; rx_overrun=0; tx_busy=rx_busy=0; levels=0; baud counter=0; synchroniser=1.
REQ-022 Reset mid-frame SHALL abort the frame: uart_tx goes high at once and FIFO contents are discarded.

Structure
REQ-023 Package uart_pkg SHALL hold the parity_mode enum, the TX/RX state enums and the RX FIFO entry struct {frame_err, parity_err, data[7:0]}.
REQ-024 Sub-module uart_fifo_sa (show-ahead synchronous FIFO, parametrised WIDTH/DEPTH) SHALL be instantiated for TX (WIDTH 8) and RX (WIDTH 10); engines and the baud generator SHALL be inline.

Verification
REQ-025 div_x16=27, 8N1; push 0xA5 -> uart_tx low for 432 clk, then bits 1,0,1,0,0,1,0,1, each 432 clk, then high.
REQ-026 7E2, loopback, push 0x55 and 0x7F -> rx_data 0x55 then 0x7F, flags 0; TX frame length 11 bits (2 stop bits).
REQ-027 Inject 8O1 frame 0x3C with wrong parity bit, then frame 0x10 with stop=0 -> entries {0,1,0x3C} and {1,0,0x10}.
REQ-028 RX_FIFO_DEPTH=4, rx_ready=0, receive 5 bytes -> rx_level=4, rx_overrun=1, first 4 bytes intact; overrun_clr -> 0.
REQ-029 2-clk low glitch on uart_rx -> no entry written, rx_busy returns 0.
REQ-030 Assert rst mid-DATA -> uart_tx=1 next edge, tx_level=0, no further transmission.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for uart_port_ex (parity codes, engine states, RX FIFO entry)
package uart_pkg;
   typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10, PAR_RSVD = 2'b11} parity_e;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
   typedef struct packed {
      logic       frame_err;
      logic       parity_err;
      logic [7:0] data;
   } rx_entry_t;
   // keeps only the low 5..8 bits selected by the data length code
   function automatic logic [7:0] bits_mask(input logic [1:0] code);
      return 8'hFF >> (2'd3 - code);
   endfunction
endpackage

// File: rtl/uart_fifo_sa.sv
// uart_fifo_sa: show-ahead synchronous FIFO
// Ports: clk/rst; i_push+i_data write; i_pop consumes head; o_data is the head
// (0 when empty); o_full/o_empty/o_level report occupancy.
module uart_fifo_sa #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr, r_rd;
   logic             w_push, w_pop;
   // extra pointer bit separates full from empty
   assign o_level = r_wr - r_rd;
   assign o_empty = r_wr == r_rd;
   assign o_full  = o_level == (AW+1)'(DEPTH);
   assign w_pop   = i_pop && !o_empty;
   // a push into a full FIFO is accepted only when the head leaves in the same cycle
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
   always_ff @(posedge clk)
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + (AW+1)'(1);
         if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
      end
endmodule

// File: rtl/uart_port_ex.sv
// uart_port_ex: UART with x16 baud generator, TX/RX engines and TX/RX FIFOs
// Ports: clk/rst; uart_rx/uart_tx serial lines; en/div_x16 baud control;
// data_bits/parity_mode/stop2 frame format; tx_* and rx_* streams;
// rx_parity_err/rx_frame_err head flags; rx_overrun sticky (overrun_clr);
// tx_busy/rx_busy engine activity; tx_level/rx_level FIFO occupancy.
module uart_port_ex import uart_pkg::*; #(
   parameter int CLK_HZ           = 50_000_000,
   parameter int DEFAULT_BAUDRATE = 9_600,
   parameter int DIV_WIDTH        = 16,
   parameter int TX_FIFO_DEPTH    = 16,
   parameter int RX_FIFO_DEPTH    = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             uart_rx,
   output logic                             uart_tx,
   input  logic                             en,
   input  logic [DIV_WIDTH-1:0]             div_x16,
   input  logic [1:0]                       data_bits,
   input  logic [1:0]                       parity_mode,
   input  logic                             stop2,
   input  logic                             tx_valid,
   output logic                             tx_ready,
   input  logic [7:0]                       tx_data,
   output logic                             rx_valid,
   input  logic                             rx_ready,
   output logic [7:0]                       rx_data,
   output logic                             rx_parity_err,
   output logic                             rx_frame_err,
   output logic                             rx_overrun,
   input  logic                             overrun_clr,
   output logic                             tx_busy,
   output logic                             rx_busy,
   output logic [$clog2(TX_FIFO_DEPTH):0]   tx_level,
   output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level
);
   localparam int DEF_DIV = CLK_HZ / (16 * DEFAULT_BAUDRATE);
   parity_e              w_pm;
   logic [DIV_WIDTH-1:0] r_baud_cnt, w_div;
   logic                 w_tick;
   assign w_pm   = parity_e'(parity_mode);
   assign w_div  = (div_x16 < DIV_WIDTH'(2)) ? DIV_WIDTH'(DEF_DIV) : div_x16;
   // >= keeps the period bounded if the divider shrinks mid-count
   assign w_tick = en && (r_baud_cnt >= w_div - DIV_WIDTH'(1));
   always_ff @(posedge clk)
      r_baud_cnt <= (rst || !en || w_tick) ? '0 : r_baud_cnt + DIV_WIDTH'(1);
   // ---------------- TX ----------------
   tx_state_e  r_tx_st, w_tx_nxt;
   logic [4:0] r_tx_cnt;
   logic [2:0] r_tx_idx, r_tx_nb;
   logic [7:0] r_tx_sh, w_tx_sh, w_tx_head;
   logic       r_tx_par, r_tx_st2, r_tx_pbit, r_uart_tx;
   logic       w_tx_line, w_tx_load, w_tx_end, w_tx_empty, w_tx_full;
   assign w_tx_end = w_tick && r_tx_cnt == ((r_tx_st == TX_STOP && r_tx_st2) ? 5'd31 : 5'd15);
   always_comb begin
      w_tx_nxt  = r_tx_st;
      w_tx_load = 1'b0;
      case (r_tx_st)
         TX_IDLE:   if (!w_tx_empty) begin
                       w_tx_load = 1'b1;
                       w_tx_nxt  = TX_START;
                    end
         TX_START:  if (w_tx_end) w_tx_nxt = TX_DATA;
         TX_DATA:   if (w_tx_end && r_tx_idx == r_tx_nb) begin
                       if (r_tx_par) w_tx_nxt = TX_PARITY;
                       else          w_tx_nxt = TX_STOP;
                    end
         TX_PARITY: if (w_tx_end) w_tx_nxt = TX_STOP;
         TX_STOP:   if (w_tx_end) begin
                       w_tx_load = !w_tx_empty;
                       if (w_tx_empty) w_tx_nxt = TX_IDLE;
                       else            w_tx_nxt = TX_START;
                    end
         default:   w_tx_nxt = TX_IDLE;
      endcase
      w_tx_sh   = w_tx_load ? w_tx_head : (r_tx_st == TX_DATA && w_tx_end) ? r_tx_sh >> 1 : r_tx_sh;
      // line level is registered from the next state so uart_tx never glitches
      w_tx_line = (w_tx_nxt == TX_START) ? 1'b0 :
                  (w_tx_nxt == TX_DATA) ? w_tx_sh[0] :
                  (w_tx_nxt == TX_PARITY) ? r_tx_pbit : 1'b1;
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_tx_st   <= TX_IDLE;
         r_uart_tx <= 1'b1;
         r_tx_sh   <= '0;
         r_tx_cnt  <= '0;
         r_tx_idx  <= '0;
         r_tx_nb   <= '0;
         r_tx_par  <= 1'b0;
         r_tx_st2  <= 1'b0;
         r_tx_pbit <= 1'b0;
      end else begin
         r_tx_st   <= w_tx_nxt;
         r_uart_tx <= w_tx_line;
         r_tx_sh   <= w_tx_sh;
         if (w_tx_load) begin
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
            r_tx_nb   <= {1'b0, data_bits} + 3'd4;
            r_tx_par  <= w_pm == PAR_EVEN || w_pm == PAR_ODD;
            r_tx_st2  <= stop2;
            r_tx_pbit <= (^(w_tx_head & bits_mask(data_bits))) ^ (w_pm == PAR_ODD);
         end else if (w_tx_end) begin
            r_tx_cnt <= '0;
            if (r_tx_st == TX_DATA) r_tx_idx <= r_tx_idx + 3'd1;
         end else if (w_tick) r_tx_cnt <= r_tx_cnt + 5'd1;
      end
   assign uart_tx  = r_uart_tx;
   assign tx_busy  = r_tx_st != TX_IDLE;
   assign tx_ready = !w_tx_full;
   uart_fifo_sa #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .i_push(tx_valid && tx_ready), .i_data(tx_data),
      .i_pop(w_tx_load), .o_data(w_tx_head), .o_full(w_tx_full),
      .o_empty(w_tx_empty), .o_level(tx_level));
   // ---------------- RX ----------------
   rx_state_e  r_rx_st, w_rx_nxt;
   logic       r_sync1, r_sync2, r_rx_prev;
   logic [3:0] r_rx_cnt;
   logic [2:0] r_rx_idx, r_rx_nb;
   logic [7:0] r_rx_sh;
   logic       r_rx_par, r_rx_odd, r_rx_perr, r_ovr;
   logic       w_rx_start, w_rx_samp, w_stop_samp, w_rx_pop, w_rx_full, w_rx_empty;
   rx_entry_t  w_rx_in, w_rx_head;
   // falling edge only counts when the previous synchronised sample was high
   assign w_rx_start  = r_rx_st == RX_IDLE && r_rx_prev && !r_sync2;
   assign w_rx_samp   = w_tick && r_rx_cnt == ((r_rx_st == RX_START) ? 4'd7 : 4'd15);
   assign w_stop_samp = r_rx_st == RX_STOP && w_rx_samp;
   assign w_rx_pop    = rx_valid && rx_ready;
   assign w_rx_in     = '{frame_err: !r_sync2, parity_err: r_rx_perr, data: r_rx_sh};
   always_comb begin
      w_rx_nxt = r_rx_st;
      case (r_rx_st)
         RX_IDLE:   if (w_rx_start) w_rx_nxt = RX_START;
         RX_START:  if (w_rx_samp) begin
                       if (r_sync2) w_rx_nxt = RX_IDLE;
                       else         w_rx_nxt = RX_DATA;
                    end
         RX_DATA:   if (w_rx_samp && r_rx_idx == r_rx_nb) begin
                       if (r_rx_par) w_rx_nxt = RX_PARITY;
                       else          w_rx_nxt = RX_STOP;
                    end
         RX_PARITY: if (w_rx_samp) w_rx_nxt = RX_STOP;
         RX_STOP:   if (w_rx_samp) w_rx_nxt = RX_IDLE;
         default:   w_rx_nxt = RX_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
         r_rx_st   <= RX_IDLE;
         r_rx_cnt  <= '0;
         r_rx_idx  <= '0;
         r_rx_nb   <= '0;
         r_rx_sh   <= '0;
         r_rx_par  <= 1'b0;
         r_rx_odd  <= 1'b0;
         r_rx_perr <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_sync1   <= uart_rx;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
         r_rx_st   <= w_rx_nxt;
         if (w_rx_start) begin
            r_rx_cnt  <= '0;
            r_rx_idx  <= '0;
            r_rx_sh   <= '0;
            r_rx_perr <= 1'b0;
            r_rx_nb   <= {1'b0, data_bits} + 3'd4;
            r_rx_par  <= w_pm == PAR_EVEN || w_pm == PAR_ODD;
            r_rx_odd  <= w_pm == PAR_ODD;
         end else if (w_rx_samp) begin
            r_rx_cnt <= '0;
            if (r_rx_st == RX_DATA) begin
               r_rx_sh[r_rx_idx] <= r_sync2;
               r_rx_idx          <= r_rx_idx + 3'd1;
            end
            if (r_rx_st == RX_PARITY) r_rx_perr <= (^r_rx_sh ^ r_rx_odd) != r_sync2;
         end else if (w_tick) r_rx_cnt <= r_rx_cnt + 4'd1;
         // set wins over a simultaneous clear
         r_ovr <= (w_stop_samp && w_rx_full && !w_rx_pop) || (r_ovr && !overrun_clr);
      end
   uart_fifo_sa #(.WIDTH(10), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .i_push(w_stop_samp), .i_data(w_rx_in),
      .i_pop(w_rx_pop), .o_data(w_rx_head), .o_full(w_rx_full),
      .o_empty(w_rx_empty), .o_level(rx_level));
   assign rx_valid      = !w_rx_empty;
   assign rx_data       = w_rx_head.data;
   assign rx_parity_err = w_rx_head.parity_err;
   assign rx_frame_err  = w_rx_head.frame_err;
   assign rx_overrun    = r_ovr;
   assign rx_busy       = r_rx_st != RX_IDLE;
endmodule

// File: tb/tb_uart_port_ex.sv
// tb_uart_port_ex: directed self-checking bench for uart_port_ex
module tb_uart_port_ex;
   logic        clk = 1'b0, rst = 1'b1, en = 1'b1, rx_drv = 1'b1, loop = 1'b0;
   logic        w_rx, uart_tx, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
   logic        stop2 = 1'b0, overrun_clr = 1'b0;
   logic        rx_parity_err, rx_frame_err, rx_overrun, tx_busy, rx_busy;
   logic [15:0] div_x16 = 16'd27;
   logic [1:0]  data_bits = 2'd3, parity_mode = 2'b00;
   logic [7:0]  tx_data = 8'h00, rx_data;
   logic [4:0]  tx_level;
   logic [2:0]  rx_level;
   int          total = 0, bad = 0;
   always #5 clk = ~clk;
   assign w_rx = loop ? uart_tx : rx_drv;
   uart_port_ex #(.RX_FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .uart_rx(w_rx), .uart_tx(uart_tx), .en(en), .div_x16(div_x16),
      .data_bits(data_bits), .parity_mode(parity_mode), .stop2(stop2),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
      .overrun_clr(overrun_clr), .tx_busy(tx_busy), .rx_busy(rx_busy),
      .tx_level(tx_level), .rx_level(rx_level));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic push(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      step(1);
      tx_valid = 1'b0;
   endtask
   task automatic run_len(input logic lvl, input int max, output int n);
      n = 0;
      while (uart_tx == lvl && n < max) begin
         step(1);
         n++;
      end
   endtask
   task automatic send(input logic [11:0] bits, input int nb, input int bt);
      for (int i = 0; i < nb; i++) begin
         rx_drv = bits[i];
         step(bt);
      end
      rx_drv = 1'b1;
      step(2 * bt);
   endtask
   task automatic pop_chk(input string tag, input logic [7:0] d, input logic pe, input logic fe);
      chk({tag, "_valid"}, rx_valid, 1'b1);
      chk({tag, "_data"}, rx_data, d);
      chk({tag, "_perr"}, rx_parity_err, pe);
      chk({tag, "_ferr"}, rx_frame_err, fe);
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
   endtask
   initial begin
      int n;
      logic [7:0] a5;
      logic [7:0] v [5];
      step(3);
      chk("rst_tx", uart_tx, 1'b1);
      chk("rst_tx_ready", tx_ready, 1'b1);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
      chk("rst_busy", {tx_busy, rx_busy}, 2'b00);
      chk("rst_levels", {tx_level, rx_level}, 8'h00);
      rst = 1'b0;
      step(2);
      // 8N1 0xA5 at 432 clk per bit
      push(8'hA5);
      n = 0;
      while (uart_tx && n < 50) begin
         step(1);
         n++;
      end
      chk("a5_start_seen", uart_tx, 1'b0);
      run_len(1'b0, 1000, n);
      chk("a5_start_len", (n >= 406 && n <= 432), 1'b1);
      run_len(1'b1, 1000, n);
      chk("a5_bit0_len", n, 432);
      run_len(1'b0, 1000, n);
      chk("a5_bit1_len", n, 432);
      a5 = 8'hA5;
      step(216);
      for (int k = 2; k < 8; k++) begin
         chk($sformatf("a5_bit%0d", k), uart_tx, a5[k]);
         step(432);
      end
      chk("a5_stop", uart_tx, 1'b1);
      chk("a5_busy_stop", tx_busy, 1'b1);
      step(432);
      chk("a5_idle_busy", tx_busy, 1'b0);
      chk("a5_idle_line", uart_tx, 1'b1);
      chk("a5_no_rx", rx_level, 3'd0);
      // 7E2 loopback, back-to-back frames
      data_bits   = 2'd2;
      parity_mode = 2'b01;
      stop2       = 1'b1;
      loop        = 1'b1;
      tx_valid    = 1'b1;
      tx_data     = 8'h55;
      step(1);
      tx_data     = 8'h7F;
      step(1);
      tx_valid    = 1'b0;
      n = 0;
      while (tx_level != 0 && n < 12000) begin
         step(1);
         n++;
      end
      chk("lb_second_load", tx_level, 5'd0);
      chk("lb_no_gap", uart_tx, 1'b0);
      n = 0;
      while (tx_busy && n < 6000) begin
         step(1);
         n++;
      end
      chk("lb_frame_len", n, 11 * 432);
      step(20);
      chk("lb_rx_level", rx_level, 3'd2);
      pop_chk("lb0", 8'h55, 1'b0, 1'b0);
      pop_chk("lb1", 8'h7F, 1'b0, 1'b0);
      chk("lb_empty", rx_valid, 1'b0);
      loop = 1'b0;
      // 8O1 injected: bad parity on 0x3C, stop=0 on 0x10
      div_x16     = 16'd8;
      data_bits   = 2'd3;
      parity_mode = 2'b10;
      stop2       = 1'b0;
      step(50);
      send({1'b1, 1'b0, 8'h3C, 1'b0}, 11, 128);
      send({1'b0, 1'b0, 8'h10, 1'b0}, 11, 128);
      chk("inj_level", rx_level, 3'd2);
      pop_chk("inj0", 8'h3C, 1'b1, 1'b0);
      pop_chk("inj1", 8'h10, 1'b0, 1'b1);
      // 8N1 overrun with a 4-deep RX FIFO
      parity_mode = 2'b00;
      v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 4; i++) send({2'b11, v[i], 1'b0}, 10, 128);
      chk("ovr_full_level", rx_level, 3'd4);
      chk("ovr_not_yet", rx_overrun, 1'b0);
      send({2'b11, v[4], 1'b0}, 10, 128);
      chk("ovr_level", rx_level, 3'd4);
      chk("ovr_set", rx_overrun, 1'b1);
      for (int i = 0; i < 4; i++) pop_chk($sformatf("ovr%0d", i), v[i], 1'b0, 1'b0);
      chk("ovr_sticky", rx_overrun, 1'b1);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      chk("ovr_clr", rx_overrun, 1'b0);
      // 2-clk low glitch
      rx_drv = 1'b0;
      step(2);
      rx_drv = 1'b1;
      step(5);
      chk("gl_busy", rx_busy, 1'b1);
      step(150);
      chk("gl_idle", rx_busy, 1'b0);
      chk("gl_no_entry", rx_level, 3'd0);
      // reset during DATA
      push(8'h00);
      push(8'h00);
      step(200);
      chk("rs_mid_low", uart_tx, 1'b0);
      chk("rs_mid_level", tx_level, 5'd1);
      rst = 1'b1;
      step(1);
      chk("rs_tx_high", uart_tx, 1'b1);
      chk("rs_level", tx_level, 5'd0);
      chk("rs_busy", tx_busy, 1'b0);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 1500; i++) begin
         step(1);
         if (!uart_tx) n++;
      end
      chk("rs_quiet", n, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
